load_store_unit: RTL and testbench

- Sits directly upstream of the word-addressed data memory. Accepts byte, halfword and word load/store requests from the core on a valid/ready handshake.
- Issues only full-word accesses to memory (option = 3'b010, address aligned to the word).
- Sub-word stores become a read-modify-write: read the word, merge the byte or halfword lane, write the word back.
- Loads are lane-extracted and sign- or zero-extended, then returned on a one-cycle response strobe.

---
 rtl/load_store_unit_if.sv | 39 +++
 rtl/load_store_unit.sv | 180 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Core request/response and word-memory bus of the load/store unit.
// The LSU connects through the slave modport; the core/memory side uses master.
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_address;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_fault;

  logic                  mem_read;
  logic                  mem_write;
  logic [2:0]            mem_option;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_response;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_funct3, req_address, req_wdata,
    input  mem_response, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_fault,
    output mem_read, mem_write, mem_option, mem_address, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_funct3, req_address, req_wdata,
    output mem_response, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
    input  mem_read, mem_write, mem_option, mem_address, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Byte/halfword/word load-store unit in front of a word-only data memory.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic clk,
  input  logic reset,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t state, state_next;

  logic                  write_q;
  logic [2:0]            funct3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] word_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  fault_q;

  logic                  req_ready;
  logic                  mem_read;
  logic                  mem_write;
  logic                  resp_valid;
  logic                  cap_req;
  logic                  cap_word;
  logic                  done_load;
  logic                  done_store;
  logic                  done_fault;
  logic                  req_illegal;
  logic                  req_misaligned;
  logic [7:0]            load_byte;
  logic [15:0]           load_half;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] merged;

  always_comb begin
    if (bus.req_write)
      req_illegal = !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010});
    else
      req_illegal = bus.req_funct3 inside {3'b011, 3'b110, 3'b111};
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // funct3[1:0] is 01 for every halfword op and 10 for word ops
  assign req_misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_address[0]) ||
                          ((bus.req_funct3[1:0] == 2'b10) && (bus.req_address[1:0] != 2'b00));
`else
  assign req_misaligned = 1'b0;
`endif

  always_comb begin
    load_byte = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    load_half = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b100:  load_data = {24'd0, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b101:  load_data = {16'd0, load_half};
      default: load_data = bus.mem_rdata;
    endcase
  end

  always_comb begin
    merged = word_q;
    case (funct3_q[1:0])
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    resp_valid = 1'b0;
    cap_req    = 1'b0;
    cap_word   = 1'b0;
    done_load  = 1'b0;
    done_store = 1'b0;
    done_fault = 1'b0;
    case (state)
      IDLE: begin
        req_ready = reset;
        if (bus.req_valid && req_ready) begin
          cap_req = 1'b1;
          if (req_illegal || req_misaligned) begin
            done_fault = 1'b1;
            state_next = DONE;
          end else if (bus.req_write && (bus.req_funct3 == 3'b010)) begin
            state_next = WRITE;
          end else begin
            state_next = READ;
          end
        end
      end
      READ: begin
        mem_read = 1'b1;
        if (bus.mem_response) begin
          cap_word = 1'b1;
          if (write_q) begin
            state_next = WRITE;
          end else begin
            done_load  = 1'b1;
            state_next = DONE;
          end
        end
      end
      WRITE: begin
        mem_write = 1'b1;
        if (bus.mem_response) begin
          done_store = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Response registers only change on the way into DONE, so they hold between responses
  always_ff @(posedge clk) begin
    if (!reset) begin
      write_q  <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      word_q   <= '0;
      rdata_q  <= '0;
      fault_q  <= 1'b0;
    end else begin
      if (cap_req) begin
        write_q  <= bus.req_write;
        funct3_q <= bus.req_funct3;
        addr_q   <= bus.req_address;
        wdata_q  <= bus.req_wdata;
      end
      if (cap_word)
        word_q <= bus.mem_rdata;
      if (done_load) begin
        rdata_q <= load_data;
        fault_q <= 1'b0;
      end
      if (done_store) begin
        rdata_q <= '0;
        fault_q <= 1'b0;
      end
      if (done_fault) begin
        rdata_q <= '0;
        fault_q <= 1'b1;
      end
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.resp_valid  = resp_valid;
  assign bus.resp_rdata  = rdata_q;
  assign bus.resp_fault  = fault_q;
  assign bus.mem_read    = mem_read;
  assign bus.mem_write   = mem_write;
  assign bus.mem_option  = 3'b010;
  assign bus.mem_address = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign bus.mem_wdata   = merged;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table plus
// hand sequences for wait states, response hold and reset mid-write.
module tb_load_store_unit;

  localparam logic [31:0] NONE = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus();

  load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Word memory model with a programmable number of wait cycles per access
  logic [31:0] mem_model [0:255];
  logic        preload_en = 1'b1;
  int          wait_req = 0;
  int          stall_cnt = 0;
  logic        strobe;

  assign strobe           = bus.mem_read | bus.mem_write;
  assign bus.mem_response = strobe && (stall_cnt >= wait_req);
  assign bus.mem_rdata    = mem_model[bus.mem_address[9:2]];

  always @(posedge clk) begin
    if (preload_en) begin
      for (int i = 0; i < 256; i++) mem_model[i] <= 32'd0;
      mem_model[64] <= 32'h8899_AABB;
      mem_model[67] <= 32'h1357_9BDF;
    end else if (bus.mem_write && bus.mem_response) begin
      mem_model[bus.mem_address[9:2]] <= bus.mem_wdata;
    end
    if (strobe && !bus.mem_response) stall_cnt <= stall_cnt + 1;
    else                             stall_cnt <= 0;
  end

  typedef struct {
    string       name;
    logic        write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_fault;
    int          exp_lat;
    int          exp_reads;
    int          exp_writes;
    logic [31:0] exp_maddr;
    logic [31:0] exp_mwdata;
  } vec_t;

  int checks = 0;
  int failures = 0;

  logic [31:0] obs_rdata, obs_maddr, obs_mwdata;
  logic        obs_fault, obs_opt_bad;
  int          obs_lat, obs_reads, obs_writes, obs_busy_ready;

  function automatic vec_t mk(string n, logic w, logic [2:0] f, logic [31:0] a, logic [31:0] wd,
                              logic [31:0] er, logic ef, int el, int ers, int ews,
                              logic [31:0] ema, logic [31:0] emw);
    vec_t v;
    v.name = n; v.write = w; v.funct3 = f; v.addr = a; v.wdata = wd;
    v.exp_rdata = er; v.exp_fault = ef; v.exp_lat = el; v.exp_reads = ers;
    v.exp_writes = ews; v.exp_maddr = ema; v.exp_mwdata = emw;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Presents one request, keeps a junk request asserted while busy, and
  // records what the DUT does until resp_valid (bounded by 40 cycles)
  task automatic applyStimulus(input logic w, input logic [2:0] f, input logic [31:0] a,
                               input logic [31:0] wd);
    @(negedge clk);
    bus.req_valid   = 1'b1;
    bus.req_write   = w;
    bus.req_funct3  = f;
    bus.req_address = a;
    bus.req_wdata   = wd;
    obs_lat = 0; obs_reads = 0; obs_writes = 0; obs_busy_ready = 0;
    obs_maddr = NONE; obs_mwdata = NONE; obs_opt_bad = 1'b0;
    obs_rdata = NONE; obs_fault = 1'b0;
    @(posedge clk);
    #1;
    bus.req_write   = 1'b1;
    bus.req_funct3  = 3'b010;
    bus.req_address = 32'h0000_01F0;
    bus.req_wdata   = 32'hBAD0_BAD0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.mem_read)  obs_reads++;
      if (bus.mem_write) begin
        obs_writes++;
        obs_mwdata = bus.mem_wdata;
      end
      if (strobe) begin
        obs_maddr = bus.mem_address;
        if (bus.mem_option !== 3'b010) obs_opt_bad = 1'b1;
      end
      if (bus.req_ready) obs_busy_ready++;
      if (bus.resp_valid) begin
        obs_lat   = k;
        obs_rdata = bus.resp_rdata;
        obs_fault = bus.resp_fault;
        break;
      end
    end
    bus.req_valid = 1'b0;
    checkOutput("no timeout", 32'(obs_lat == 0), 32'd0);
  endtask

  task automatic runVector(input vec_t v);
    applyStimulus(v.write, v.funct3, v.addr, v.wdata);
    checkOutput({v.name, " rdata"},   obs_rdata,                  v.exp_rdata);
    checkOutput({v.name, " fault"},   32'(obs_fault),             32'(v.exp_fault));
    checkOutput({v.name, " latency"}, 32'(obs_lat),               32'(v.exp_lat));
    checkOutput({v.name, " reads"},   32'(obs_reads),             32'(v.exp_reads));
    checkOutput({v.name, " writes"},  32'(obs_writes),            32'(v.exp_writes));
    checkOutput({v.name, " maddr"},   obs_maddr,                  v.exp_maddr);
    checkOutput({v.name, " mwdata"},  obs_mwdata,                 v.exp_mwdata);
    checkOutput({v.name, " ready while busy"}, 32'(obs_busy_ready), 32'd0);
    checkOutput({v.name, " option"},  32'(obs_opt_bad),           32'd0);
  endtask

  vec_t vecs[21];

  initial begin
    bus.req_valid   = 1'b0;
    bus.req_write   = 1'b0;
    bus.req_funct3  = 3'b000;
    bus.req_address = 32'd0;
    bus.req_wdata   = 32'd0;

    //          name       w     f3      addr          wdata          rdata          flt lat rd wr maddr          mwdata
    vecs[0]  = mk("LB 103",  1'b0, 3'b000, 32'h103, 32'h0,         32'hFFFF_FF88, 1'b0, 2, 1, 0, 32'h100, NONE);
    vecs[1]  = mk("LBU 100", 1'b0, 3'b100, 32'h100, 32'h0,         32'h0000_00BB, 1'b0, 2, 1, 0, 32'h100, NONE);
    vecs[2]  = mk("LHU 102", 1'b0, 3'b101, 32'h102, 32'h0,         32'h0000_8899, 1'b0, 2, 1, 0, 32'h100, NONE);
    vecs[3]  = mk("LH 100",  1'b0, 3'b001, 32'h100, 32'h0,         32'hFFFF_AABB, 1'b0, 2, 1, 0, 32'h100, NONE);
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[4]  = mk("LH 101",  1'b0, 3'b001, 32'h101, 32'h0,         32'h0,         1'b1, 1, 0, 0, NONE,    NONE);
    vecs[5]  = mk("LW 102",  1'b0, 3'b010, 32'h102, 32'h0,         32'h0,         1'b1, 1, 0, 0, NONE,    NONE);
`else
    vecs[4]  = mk("LH 101",  1'b0, 3'b001, 32'h101, 32'h0,         32'hFFFF_AABB, 1'b0, 2, 1, 0, 32'h100, NONE);
    vecs[5]  = mk("LW 102",  1'b0, 3'b010, 32'h102, 32'h0,         32'h8899_AABB, 1'b0, 2, 1, 0, 32'h100, NONE);
`endif
    vecs[6]  = mk("SB 101",  1'b1, 3'b000, 32'h101, 32'h1234_5677, 32'h0,         1'b0, 3, 1, 1, 32'h100, 32'h8899_77BB);
    vecs[7]  = mk("LW 100a", 1'b0, 3'b010, 32'h100, 32'h0,         32'h8899_77BB, 1'b0, 2, 1, 0, 32'h100, NONE);
    vecs[8]  = mk("SH 102",  1'b1, 3'b001, 32'h102, 32'h0000_CAFE, 32'h0,         1'b0, 3, 1, 1, 32'h100, 32'hCAFE_77BB);
    vecs[9]  = mk("LW 100b", 1'b0, 3'b010, 32'h100, 32'h0,         32'hCAFE_77BB, 1'b0, 2, 1, 0, 32'h100, NONE);
    vecs[10] = mk("SW 104",  1'b1, 3'b010, 32'h104, 32'hDEAD_BEEF, 32'h0,         1'b0, 2, 0, 1, 32'h104, 32'hDEAD_BEEF);
    vecs[11] = mk("LB 105",  1'b0, 3'b000, 32'h105, 32'h0,         32'hFFFF_FFBE, 1'b0, 2, 1, 0, 32'h104, NONE);
    vecs[12] = mk("LBU 106", 1'b0, 3'b100, 32'h106, 32'h0,         32'h0000_00AD, 1'b0, 2, 1, 0, 32'h104, NONE);
    vecs[13] = mk("LHU 106", 1'b0, 3'b101, 32'h106, 32'h0,         32'h0000_DEAD, 1'b0, 2, 1, 0, 32'h104, NONE);
    vecs[14] = mk("LH 104",  1'b0, 3'b001, 32'h104, 32'h0,         32'hFFFF_BEEF, 1'b0, 2, 1, 0, 32'h104, NONE);
    vecs[15] = mk("LD f011", 1'b0, 3'b011, 32'h100, 32'h0,         32'h0,         1'b1, 1, 0, 0, NONE,    NONE);
    vecs[16] = mk("ST f100", 1'b1, 3'b100, 32'h100, 32'h5555_5555, 32'h0,         1'b1, 1, 0, 0, NONE,    NONE);
    vecs[17] = mk("LD f110", 1'b0, 3'b110, 32'h104, 32'h0,         32'h0,         1'b1, 1, 0, 0, NONE,    NONE);
    vecs[18] = mk("ST f011", 1'b1, 3'b011, 32'h104, 32'h5555_5555, 32'h0,         1'b1, 1, 0, 0, NONE,    NONE);
    vecs[19] = mk("SB 107",  1'b1, 3'b000, 32'h107, 32'h0000_00A5, 32'h0,         1'b0, 3, 1, 1, 32'h104, 32'hA5AD_BEEF);
    vecs[20] = mk("LB 107",  1'b0, 3'b000, 32'h107, 32'h0,         32'hFFFF_FFA5, 1'b0, 2, 1, 0, 32'h104, NONE);

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset req_ready",  32'(bus.req_ready),  32'd0);
    checkOutput("reset mem_read",   32'(bus.mem_read),   32'd0);
    checkOutput("reset mem_write",  32'(bus.mem_write),  32'd0);
    checkOutput("reset resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("reset resp_fault", 32'(bus.resp_fault), 32'd0);
    checkOutput("reset resp_rdata", bus.resp_rdata,      32'd0);
    preload_en = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("post-reset req_ready", 32'(bus.req_ready), 32'd1);

    for (int i = 0; i < 21; i++) runVector(vecs[i]);

    // Two stall cycles on a store, then one on a load
    wait_req = 2;
    runVector(mk("SW 108 ws2", 1'b1, 3'b010, 32'h108, 32'h0102_0304, 32'h0, 1'b0, 4, 0, 3, 32'h108, 32'h0102_0304));
    wait_req = 1;
    runVector(mk("LW 108 ws1", 1'b0, 3'b010, 32'h108, 32'h0, 32'h0102_0304, 1'b0, 3, 2, 0, 32'h108, NONE));
    wait_req = 0;

    @(negedge clk);
    checkOutput("resp_valid one cycle", 32'(bus.resp_valid), 32'd0);
    checkOutput("resp_rdata held",      bus.resp_rdata,      32'h0102_0304);
    checkOutput("ready after DONE",     32'(bus.req_ready),  32'd1);

    // Abort a stalled write with reset; the memory word must stay untouched
    wait_req = 1000;
    @(negedge clk);
    bus.req_valid   = 1'b1;
    bus.req_write   = 1'b1;
    bus.req_funct3  = 3'b010;
    bus.req_address = 32'h10C;
    bus.req_wdata   = 32'h0000_0055;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    checkOutput("stalled mem_write", 32'(bus.mem_write), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abort mem_write",  32'(bus.mem_write),  32'd0);
    checkOutput("abort mem_read",   32'(bus.mem_read),   32'd0);
    checkOutput("abort req_ready",  32'(bus.req_ready),  32'd0);
    checkOutput("abort resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("abort resp_rdata", bus.resp_rdata,      32'd0);
    reset = 1'b1;
    wait_req = 0;
    #1;
    checkOutput("release req_ready", 32'(bus.req_ready), 32'd1);
    runVector(mk("LW 10C", 1'b0, 3'b010, 32'h10C, 32'h0, 32'h1357_9BDF, 1'b0, 2, 1, 0, 32'h10C, NONE));
    runVector(mk("LW 100c", 1'b0, 3'b010, 32'h100, 32'h0, 32'hCAFE_77BB, 1'b0, 2, 1, 0, 32'h100, NONE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
